// File: rtl/store_unit_if.sv
// Store-unit bus bundle: execute-side store request, data-memory write port and load-hazard probe.
// master = environment (execute stage + memory), slave = store_unit.
interface store_unit_if;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_funct3;
  logic        dmem_req;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_we;
  logic        dmem_ack;
  logic [31:0] ld_check_addr;
  logic        ld_hazard;
  logic        misalign;
  logic        empty;

  modport master (
    output st_valid, st_addr, st_data, st_funct3, dmem_ack, ld_check_addr,
    input  st_ready, dmem_req, dmem_addr, dmem_wdata, dmem_we, ld_hazard, misalign, empty
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_funct3, dmem_ack, ld_check_addr,
    output st_ready, dmem_req, dmem_addr, dmem_wdata, dmem_we, ld_hazard, misalign, empty
  );
endinterface

// File: rtl/store_unit.sv
// In-order store buffer: encodes SB/SH/SW into lane-aligned words and drains one per dmem_ack.
// STORE_MISALIGN_CHECK_EN: reject misaligned SH/SW and pulse misalign for one cycle.
module store_unit #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  store_unit_if.slave bus
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW:0]   r_count;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [31:0]   r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [3:0]    r_mask [DEPTH];

  logic        w_legal;
  logic        w_misaligned;
  logic        w_push;
  logic        w_pop;
  logic        w_hazard;
  logic [31:0] w_enc_data;
  logic [3:0]  w_enc_mask;
  logic        w_unused;

  assign bus.st_ready = (r_count < (PW+1)'(DEPTH));
  assign bus.empty    = (r_count == '0);
  assign w_legal      = (bus.st_funct3 == 3'b000) || (bus.st_funct3 == 3'b001) ||
                        (bus.st_funct3 == 3'b010);
  assign w_push       = bus.st_valid && bus.st_ready && w_legal && !w_misaligned;
  assign w_pop        = bus.dmem_ack && (r_state == S_ISSUE);
  assign w_unused     = &{1'b0, bus.ld_check_addr[1:0]};

`ifdef STORE_MISALIGN_CHECK_EN
  logic r_misalign;

  assign w_misaligned = ((bus.st_funct3 == 3'b001) && bus.st_addr[0]) ||
                        ((bus.st_funct3 == 3'b010) && (bus.st_addr[1:0] != 2'b00));

  always_ff @(posedge clk) begin
    if (reset) r_misalign <= 1'b0;
    else       r_misalign <= bus.st_valid && bus.st_ready && w_misaligned;
  end

  assign bus.misalign = r_misalign;
`else
  assign w_misaligned = 1'b0;
  assign bus.misalign = 1'b0;
`endif

  // Replicate the source bytes across all lanes; the mask picks the live ones.
  always_comb begin
    w_enc_mask = 4'b1111;
    w_enc_data = bus.st_data;
    case (bus.st_funct3)
      3'b000: begin
        w_enc_mask = 4'b0001 << bus.st_addr[1:0];
        w_enc_data = {4{bus.st_data[7:0]}};
      end
      3'b001: begin
        w_enc_mask = 4'b0011 << {bus.st_addr[1], 1'b0};
        w_enc_data = {2{bus.st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_addr[r_wptr] <= {bus.st_addr[31:2], 2'b00};
      r_data[r_wptr] <= w_enc_data;
      r_mask[r_wptr] <= w_enc_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_push) w_state_nxt = S_ISSUE;
      S_ISSUE: if (w_pop && (r_count == (PW+1)'(1)) && !w_push) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.dmem_req   = 1'b0;
    bus.dmem_addr  = '0;
    bus.dmem_wdata = '0;
    bus.dmem_we    = '0;
    if (r_state == S_ISSUE) begin
      bus.dmem_req   = 1'b1;
      bus.dmem_addr  = r_addr[r_rptr];
      bus.dmem_wdata = r_data[r_rptr];
      bus.dmem_we    = r_mask[r_rptr];
    end
  end

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin : g_hz
      logic [PW-1:0] off;
      off = PW'(i) - r_rptr;
      if (({1'b0, off} < r_count) && (r_addr[i][31:2] == bus.ld_check_addr[31:2]))
        w_hazard = 1'b1;
    end
  end

  assign bus.ld_hazard = w_hazard;
endmodule

// File: tb/tb_store_unit.sv
// Randomized + directed bench for store_unit against a queue-based reference model.
module tb_store_unit;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  store_unit_if bus();

  store_unit #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  ent_t q[$];
  bit   exp_mis  = 1'b0;
  bit   model_on = 1'b0;
  int   n_cmp    = 0;
  int   n_err    = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Byte-lane view: n-byte store lands on the n-aligned lane group, source bytes repeat.
  function automatic ent_t encode(logic [31:0] a, logic [31:0] d, logic [2:0] f);
    ent_t e;
    int   n, off;
    e = '0;
    if (f > 3'd2) return e;
    n      = 1 << f;
    off    = int'(a[1:0]) & (4 - n);
    e.addr = a & 32'hFFFF_FFFC;
    e.mask = 4'(((1 << n) - 1) << off);
    for (int b = 0; b < 4; b++) e.data[8*b +: 8] = d[8*(b % n) +: 8];
    return e;
  endfunction

  task automatic check_state();
    bit hz = 1'b0;
    foreach (q[i]) if (q[i].addr[31:2] == bus.ld_check_addr[31:2]) hz = 1'b1;
    check("st_ready", bus.st_ready, q.size() < DEPTH);
    check("empty", bus.empty, q.size() == 0);
    check("dmem_req", bus.dmem_req, q.size() != 0);
    check("misalign", bus.misalign, exp_mis);
    check("ld_hazard", bus.ld_hazard, hz);
    if (q.size() != 0) begin
      check("dmem_addr", bus.dmem_addr, q[0].addr);
      check("dmem_wdata", bus.dmem_wdata, q[0].data);
      check("dmem_we", bus.dmem_we, q[0].mask);
    end
  endtask

  task automatic set_in(bit v, logic [31:0] a, logic [31:0] d, logic [2:0] f, bit ack,
                        logic [31:0] ld);
    bus.st_valid      = v;
    bus.st_addr       = a;
    bus.st_data       = d;
    bus.st_funct3     = f;
    bus.dmem_ack      = ack;
    bus.ld_check_addr = ld;
  endtask

  // Called just after a negedge with inputs applied; returns at the next negedge.
  task automatic step();
    ent_t e;
    bit   push, pop, mis;
    #1;
    if (model_on) check_state();
    push = 1'b0;
    pop  = 1'b0;
    mis  = 1'b0;
    e    = encode(bus.st_addr, bus.st_data, bus.st_funct3);
    if (!reset) begin
      pop = bus.dmem_ack && (q.size() != 0);
      if (bus.st_valid && (q.size() < DEPTH) && (bus.st_funct3 <= 3'd2)) begin
`ifdef STORE_MISALIGN_CHECK_EN
        if ((bus.st_addr % (1 << bus.st_funct3)) != 0) mis = 1'b1;
        else push = 1'b1;
`else
        push = 1'b1;
`endif
      end
    end
    @(posedge clk);
    if (reset) q.delete();
    else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(e);
    end
    exp_mis = mis;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < DEPTH + 2 && q.size() != 0; k++) begin
      set_in(0, 0, 0, 0, 1, 0);
      step();
    end
    check("drained", bus.empty, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    set_in(1, 32'h10, 32'h55, 3'b010, 1, 0);
    step();
    model_on = 1'b1;
    reset = 1'b0;
    check("rst_empty", bus.empty, 1'b1);
    check("rst_ready", bus.st_ready, 1'b1);
    check("rst_req", bus.dmem_req, 1'b0);
    check("rst_we", bus.dmem_we, 4'b0000);
    check("rst_mis", bus.misalign, 1'b0);

    // SB with ack held high in the accept cycle (no request yet, ack ignored)
    set_in(1, 32'h1003, 32'h0000_00AB, 3'b000, 1, 0);
    step();
    check("sb_req", bus.dmem_req, 1'b1);
    check("sb_addr", bus.dmem_addr, 32'h1000);
    check("sb_we", bus.dmem_we, 4'b1000);
    check("sb_wdata", bus.dmem_wdata, 32'hABAB_ABAB);
    set_in(0, 0, 0, 0, 1, 0);
    step();
    check("sb_empty", bus.empty, 1'b1);

    // SH then SW with memory stalled
    set_in(1, 32'h2002, 32'h0000_1234, 3'b001, 0, 0);
    step();
    set_in(1, 32'h2004, 32'hDEAD_BEEF, 3'b010, 0, 0);
    step();
    check("sh_we", bus.dmem_we, 4'b1100);
    check("sh_wdata", bus.dmem_wdata, 32'h1234_1234);
    check("full_ready", bus.st_ready, 1'b0);
    set_in(0, 0, 0, 0, 0, 0);
    step();
    step();
    check("sh_stable_addr", bus.dmem_addr, 32'h2000);
    check("sh_stable_we", bus.dmem_we, 4'b1100);
    set_in(0, 0, 0, 0, 1, 0);
    step();
    check("sw_addr", bus.dmem_addr, 32'h2004);
    check("sw_we", bus.dmem_we, 4'b1111);
    check("sw_wdata", bus.dmem_wdata, 32'hDEAD_BEEF);
    step();
    check("sw_empty", bus.empty, 1'b1);

    // Full buffer: push with simultaneous ack is refused
    set_in(1, 32'h5000, 32'h1, 3'b010, 0, 0);
    step();
    set_in(1, 32'h5004, 32'h2, 3'b010, 0, 0);
    step();
    set_in(1, 32'h5008, 32'h3, 3'b010, 1, 0);
    check("full_refuse", bus.st_ready, 1'b0);
    step();
    check("full_after_empty", bus.empty, 1'b0);
    check("full_after_ready", bus.st_ready, 1'b1);
    check("full_after_head", bus.dmem_addr, 32'h5004);
    drain();

    // Load hazard probe
    set_in(1, 32'h3000, 32'h77, 3'b010, 0, 0);
    step();
    set_in(0, 0, 0, 0, 0, 32'h3002);
    #1 check("hz_hit", bus.ld_hazard, 1'b1);
    bus.ld_check_addr = 32'h3004;
    #1 check("hz_miss", bus.ld_hazard, 1'b0);
    drain();

    // Misaligned word store
    set_in(1, 32'h4001, 32'h9, 3'b010, 0, 0);
    step();
`ifdef STORE_MISALIGN_CHECK_EN
    check("mis_pulse", bus.misalign, 1'b1);
    check("mis_noreq", bus.dmem_req, 1'b0);
    set_in(0, 0, 0, 0, 0, 0);
    step();
    check("mis_clear", bus.misalign, 1'b0);
`else
    check("mis_addr", bus.dmem_addr, 32'h4000);
    check("mis_we", bus.dmem_we, 4'b1111);
    drain();
`endif

    // Reset while a request is outstanding
    set_in(1, 32'h6000, 32'h5, 3'b010, 0, 0);
    step();
    check("pre_rst_req", bus.dmem_req, 1'b1);
    reset = 1'b1;
    set_in(1, 32'h6004, 32'h6, 3'b010, 1, 0);
    step();
    reset = 1'b0;
    check("post_rst_req", bus.dmem_req, 1'b0);
    check("post_rst_empty", bus.empty, 1'b1);
    check("post_rst_ready", bus.st_ready, 1'b1);

    // Randomized traffic over a small address window to provoke hazards
    for (int it = 0; it < 600; it++) begin
      reset = ($urandom_range(0, 79) == 0);
      set_in($urandom_range(0, 3) != 0,
             32'h100 + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3),
             $urandom,
             3'($urandom_range(0, 4)),
             $urandom_range(0, 1) == 1,
             32'h100 + ($urandom_range(0, 4) << 2) + $urandom_range(0, 3));
      step();
    end
    reset = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning store-buffer entries (power of 2, legal 2..8).
REQ-002 The block SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port st_valid  input  1  store request from execute stage.
REQ-005 The block SHALL have port st_ready  output  1  buffer can accept a store this cycle.
REQ-006 The block SHALL have port st_addr  input  32  byte address (ALU result).
REQ-007 The block SHALL have port st_data  input  32  rs2 value, unaligned.
REQ-008 The block SHALL have port st_funct3  input  3  000 SB, 001 SH, 010 SW.
REQ-009 The block SHALL have port dmem_req  output  1  write request to data memory.
REQ-010 The block SHALL have port dmem_addr  output  32  word address, bits [1:0] always 0.
REQ-011 The block SHALL have port dmem_wdata  output  32  lane-aligned write data.
REQ-012 The block SHALL have port dmem_we  output  4  byte write enables, bit n = byte lane n.
REQ-013 The block SHALL have port dmem_ack  input  1  memory accepted current request.
REQ-014 The block SHALL have port ld_check_addr  input  32  address of load in flight.
REQ-015 The block SHALL have port ld_hazard  output  1  a buffered store targets the load's word.
REQ-016 The block SHALL have ports misalign  output  1  and empty  output  1  (buffer holds no entries).

Function
REQ-017 A store SHALL be enqueued on a rising edge with st_valid=1, st_ready=1 and st_funct3 in {000,001,010}; other funct3 values are dropped silently.
REQ-018 st_ready SHALL equal (count < DEPTH) from registered count; a pop in the same cycle does not raise st_ready.
REQ-019 Entry encoding: addr = {st_addr[31:2],2'b00}; SB mask 4'b0001<<st_addr[1:0], data = {4{st_data[7:0]}}; SH mask 4'b0011<<{st_addr[1],1'b0}, data = {2{st_data[15:0]}}; SW mask 4'b1111, data = st_data.
REQ-020 Drain FSM SHALL have states IDLE and ISSUE; IDLE->ISSUE when count becomes nonzero; ISSUE->IDLE on dmem_ack when count=1 with no push; otherwise remain in ISSUE.
REQ-021 In ISSUE, dmem_req SHALL be 1 and dmem_addr/wdata/we SHALL present the head entry, held stable until the cycle dmem_ack=1.
REQ-022 dmem_ack SHALL pop the head on that edge; the next entry is presented the following cycle, allowing back-to-back acks at one store/cycle.
REQ-023 Minimum latency: a store accepted at edge N SHALL drive dmem_req=1 in cycle N+1.
REQ-024 dmem_ack while dmem_req=0 SHALL be ignored.
REQ-025 Simultaneous push and pop SHALL leave count unchanged; read/write pointers wrap modulo DEPTH.
REQ-026 ld_hazard SHALL be combinational: 1 iff any valid entry has addr[31:2] == ld_check_addr[31:2]; the entry being acked this cycle still counts.
REQ-027 empty SHALL equal (count == 0); stores complete strictly in acceptance order.

Reset
REQ-028 On reset=1 at a rising edge: count, pointers 0; state IDLE; dmem_req 0; dmem_we 0; misalign 0; hence empty=1, st_ready=1; buffered entries discarded, including an unacked request.
REQ-029 Reset SHALL take priority over simultaneous st_valid and dmem_ack.

Configuration
REQ-030 With macro STORE_MISALIGN_CHECK_EN defined: SH with st_addr[0]=1 or SW with st_addr[1:0]!=0 SHALL not be enqueued and misalign SHALL be 1 for exactly the cycle after the offending edge.
REQ-031 Without STORE_MISALIGN_CHECK_EN: misalign SHALL be tied 0; SH ignores st_addr[0], SW ignores st_addr[1:0], per REQ-019 encoding.

Verification
REQ-032 SB addr 0x1003 data 0x000000AB, dmem_ack=1 -> next cycle dmem_req=1, addr 0x1000, we 4'b1000, wdata 0xABABABAB; empty=1 after ack.
REQ-033 SH addr 0x2002 data 0x1234, SW addr 0x2004 data 0xDEADBEEF, ack held 0 for 3 cycles -> first request stable (we 4'b1100), st_ready=0 after both; acks drain in order, second we 4'b1111.
REQ-034 DEPTH=2 full, push attempt with ack same cycle -> push refused (st_ready=0), count 1 afterwards.
REQ-035 Buffer holds SW to 0x3000; ld_check_addr 0x3002 -> ld_hazard=1; 0x3004 -> ld_hazard=0.
REQ-036 SW addr 0x4001: with STORE_MISALIGN_CHECK_EN misalign pulses 1 cycle, no dmem_req; without it dmem_addr 0x4000, we 4'b1111.
REQ-037 Reset asserted while dmem_req=1 unacked -> next cycle dmem_req=0, empty=1, st_ready=1.
